// File: rtl/instr_encoder_loader.sv
// Accepts instruction fields, encodes them to 32-bit words and streams them into instruction memory.
// Optional macro ENCODER_NOP_PAD_EN: on finish, zero-fill the remaining addresses before DONE.
module instr_encoder_loader #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [15:0]       imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              done,
  output logic              err_illegal
);

  typedef enum logic [2:0] {IDLE, LOAD, FULL, PAD, DONE} state_t;

  localparam logic [ADDR_W:0] FULL_CNT = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] LAST     = FULL_CNT - 1'b1;

  state_t            state, state_nx, end_state;
  logic [ADDR_W:0]   ptr;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              fin_q;
  logic              err_q;
  logic              xfer;
  logic              legal;
  logic [5:0]        code;
  logic [31:0]       enc;

  assign in_ready = (state == LOAD) && (count < FULL_CNT) && !fin_q;
  assign xfer     = in_valid && in_ready;
  assign legal    = (op <= 4'd9);

  always_comb begin
    code = '0;
    enc  = '0;
    unique case (op)
      4'd0:    code = 6'b100000;
      4'd1:    code = 6'b100010;
      4'd2:    code = 6'b100100;
      4'd3:    code = 6'b100101;
      4'd4:    code = 6'b011000;
      4'd5:    code = 6'b000100;
      4'd6:    code = 6'b001000;
      4'd7:    code = 6'b001001;
      4'd8:    code = 6'b100011;
      4'd9:    code = 6'b101011;
      default: code = '0;
    endcase
    if (op <= 4'd4) enc = {6'b000000, rs, rt, rd, 5'b00000, code};
    else            enc = {code, rs, rt, imm};
  end

  always_comb begin
`ifdef ENCODER_NOP_PAD_EN
    end_state = (ptr < FULL_CNT) ? PAD : DONE;
`else
    end_state = DONE;
`endif
  end

  // A transfer coinciding with finish sets fin_q; the session ends one cycle
  // later, after that word's write strobe has gone out.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, DONE: if (start) state_nx = LOAD;
      LOAD: begin
        if (fin_q)                                         state_nx = end_state;
        else if (finish && !(xfer && legal))               state_nx = end_state;
        else if (xfer && legal && (count == LAST))         state_nx = FULL;
      end
      FULL:    if (fin_q || finish) state_nx = end_state;
      PAD:     if (ptr == LAST)     state_nx = DONE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      count   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      fin_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nx;
      we_q  <= 1'b0;
      fin_q <= (state == LOAD) && !fin_q && finish && xfer && legal;
      if ((state == IDLE || state == DONE) && start) begin
        ptr   <= '0;
        count <= '0;
        err_q <= 1'b0;
      end
      if (xfer) begin
        if (legal) begin
          we_q    <= 1'b1;
          addr_q  <= ptr[ADDR_W-1:0];
          wdata_q <= enc;
          ptr     <= ptr + 1'b1;
          count   <= count + 1'b1;
        end else begin
          err_q <= 1'b1;
        end
      end
      if (state == PAD) ptr <= ptr + 1'b1;
    end
  end

  // PAD writes come straight from the pointer so the last one lands before DONE.
  assign imem_we     = we_q || (state == PAD);
  assign imem_addr   = (state == PAD) ? ptr[ADDR_W-1:0] : addr_q;
  assign imem_wdata  = (state == PAD) ? '0 : wdata_q;
  assign busy        = (state == LOAD) || (state == FULL) || (state == PAD);
  assign done        = (state == DONE);
  assign err_illegal = err_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: three depths driven in parallel, checked against a session-level model.
module tb_instr_encoder_loader;

`ifdef ENCODER_NOP_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif
  localparam int DEP [3] = '{256, 4, 8};

  logic clk = 1'b0;
  logic rst, start, finish, in_valid;
  logic [3:0] op;
  logic [4:0] rs, rt, rd;
  logic [15:0] imm;

  logic rdy0, we0, busy0, done0, err0;
  logic [7:0] addr0; logic [31:0] wd0; logic [8:0] cnt0;
  logic rdy1, we1, busy1, done1, err1;
  logic [1:0] addr1; logic [31:0] wd1; logic [2:0] cnt1;
  logic rdy2, we2, busy2, done2, err2;
  logic [2:0] addr2; logic [31:0] wd2; logic [3:0] cnt2;

  instr_encoder_loader #(.DEPTH(256)) u0 (
    .clk(clk), .rst(rst), .start(start), .finish(finish), .in_valid(in_valid), .in_ready(rdy0),
    .op(op), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .imem_we(we0), .imem_addr(addr0),
    .imem_wdata(wd0), .count(cnt0), .busy(busy0), .done(done0), .err_illegal(err0));
  instr_encoder_loader #(.DEPTH(4)) u1 (
    .clk(clk), .rst(rst), .start(start), .finish(finish), .in_valid(in_valid), .in_ready(rdy1),
    .op(op), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .imem_we(we1), .imem_addr(addr1),
    .imem_wdata(wd1), .count(cnt1), .busy(busy1), .done(done1), .err_illegal(err1));
  instr_encoder_loader #(.DEPTH(8)) u2 (
    .clk(clk), .rst(rst), .start(start), .finish(finish), .in_valid(in_valid), .in_ready(rdy2),
    .op(op), .rs(rs), .rt(rt), .rd(rd), .imm(imm), .imem_we(we2), .imem_addr(addr2),
    .imem_wdata(wd2), .count(cnt2), .busy(busy2), .done(done2), .err_illegal(err2));

  always #5 clk = ~clk;

  logic        a_rdy [3], a_we [3], a_busy [3], a_done [3], a_err [3];
  logic [31:0] a_addr [3], a_wd [3], a_cnt [3];
  always_comb begin
    a_rdy[0] = rdy0; a_we[0] = we0; a_busy[0] = busy0; a_done[0] = done0; a_err[0] = err0;
    a_addr[0] = 32'(addr0); a_wd[0] = wd0; a_cnt[0] = 32'(cnt0);
    a_rdy[1] = rdy1; a_we[1] = we1; a_busy[1] = busy1; a_done[1] = done1; a_err[1] = err1;
    a_addr[1] = 32'(addr1); a_wd[1] = wd1; a_cnt[1] = 32'(cnt1);
    a_rdy[2] = rdy2; a_we[2] = we2; a_busy[2] = busy2; a_done[2] = done2; a_err[2] = err2;
    a_addr[2] = 32'(addr2); a_wd[2] = wd2; a_cnt[2] = 32'(cnt2);
  end

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] encode(input int o, input logic [4:0] s, input logic [4:0] t,
                                         input logic [4:0] d, input logic [15:0] i);
    logic [5:0] funct [5];
    logic [5:0] opc [5];
    funct = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h18};
    opc   = '{6'h04, 6'h08, 6'h09, 6'h23, 6'h2B};
    if (o < 5) return {6'b0, s, t, d, 5'b0, funct[o]};
    return {opc[o-5], s, t, i};
  endfunction

  // Session model: 0 idle, 1 loading (full is just count==depth), 2 padding, 3 done.
  int          m_sess [3], m_cnt [3], m_wp [3], m_addr [3];
  bit          m_err [3], m_fw [3], m_we [3];
  logic [31:0] m_data [3];

  always @(posedge clk) begin : model
    bit rdy, ok;
    for (int k = 0; k < 3; k++) begin
      rdy = (m_sess[k] == 1) && (m_cnt[k] < DEP[k]) && !m_fw[k];
      m_we[k] = 1'b0;
      ok = 1'b0;
      if (rst) begin
        m_sess[k] = 0; m_cnt[k] = 0; m_wp[k] = 0; m_err[k] = 0; m_fw[k] = 0;
      end else begin
        case (m_sess[k])
          0, 3: if (start) begin
            m_sess[k] = 1; m_cnt[k] = 0; m_wp[k] = 0; m_err[k] = 0;
          end
          1: if (m_fw[k]) begin
            m_fw[k] = 0;
            m_sess[k] = (PAD_EN && m_wp[k] < DEP[k]) ? 2 : 3;
          end else begin
            if (in_valid && rdy) begin
              if (int'(op) <= 9) begin
                m_we[k] = 1'b1; m_addr[k] = m_wp[k];
                m_data[k] = encode(int'(op), rs, rt, rd, imm);
                m_wp[k]++; m_cnt[k]++; ok = 1'b1;
              end else m_err[k] = 1'b1;
            end
            if (finish) begin
              if (ok) m_fw[k] = 1'b1;
              else m_sess[k] = (PAD_EN && m_wp[k] < DEP[k]) ? 2 : 3;
            end
          end
          2: begin
            m_wp[k]++;
            if (m_wp[k] == DEP[k]) m_sess[k] = 3;
          end
          default: m_sess[k] = 0;
        endcase
        if (m_sess[k] == 2) begin
          m_we[k] = 1'b1; m_addr[k] = m_wp[k]; m_data[k] = '0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("d%0d.in_ready", k), 32'(a_rdy[k]),
            32'((m_sess[k] == 1) && (m_cnt[k] < DEP[k]) && !m_fw[k]));
        chk($sformatf("d%0d.imem_we", k), 32'(a_we[k]), 32'(m_we[k]));
        chk($sformatf("d%0d.count", k), a_cnt[k], 32'(m_cnt[k]));
        chk($sformatf("d%0d.busy", k), 32'(a_busy[k]), 32'(m_sess[k] == 1 || m_sess[k] == 2));
        chk($sformatf("d%0d.done", k), 32'(a_done[k]), 32'(m_sess[k] == 3));
        chk($sformatf("d%0d.err", k), 32'(a_err[k]), 32'(m_err[k]));
        if (m_we[k]) begin
          chk($sformatf("d%0d.addr", k), a_addr[k], 32'(m_addr[k]));
          chk($sformatf("d%0d.wdata", k), a_wd[k], m_data[k]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int o, input int s, input int t, input int d, input int i, input bit fin);
    op = 4'(o); rs = 5'(s); rt = 5'(t); rd = 5'(d); imm = 16'(i);
    in_valid = 1'b1; finish = fin;
    tick();
    in_valid = 1'b0; finish = 1'b0;
  endtask

  task automatic wait_all_done();
    int n = 0;
    while (!(done0 && done1 && done2) && n < 400) begin
      tick();
      n++;
    end
    n_cmp++;
    if (!(done0 && done1 && done2)) begin
      n_bad++;
      $display("FAIL wait_done: got done=%b%b%b expected 111 within 400 cycles", done0, done1, done2);
    end
  endtask

  int          v_op [5] = '{7, 8, 9, 6, 4};
  int          v_rs [5] = '{0, 2, 2, 1, 1};
  int          v_rt [5] = '{5, 4, 4, 2, 2};
  int          v_rd [5] = '{31, 9, 17, 5, 3};
  int          v_im [5] = '{7, 16, 4, 16'hFFFE, 16'h1234};
  logic [31:0] v_ex [5] = '{32'h24050007, 32'h8C440010, 32'hAC440004, 32'h2022FFFE, 32'h00221818};

  initial begin
    rst = 1'b1; start = 1'b0; finish = 1'b0; in_valid = 1'b0;
    op = '0; rs = '0; rt = '0; rd = '0; imm = '0;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst.in_ready", 32'(rdy0), 32'd0);
    chk("rst.busy", 32'(busy0), 32'd0);
    chk("rst.count", 32'(cnt0), 32'd0);

    // single ADD
    start = 1'b1; tick(); start = 1'b0;
    send(0, 1, 2, 3, 0, 1'b0);
    chk("add.we", 32'(we0), 32'd1);
    chk("add.addr", 32'(addr0), 32'd0);
    chk("add.wdata", wd0, 32'h00221820);
    chk("add.count", 32'(cnt0), 32'd1);
    finish = 1'b1; tick(); finish = 1'b0;
    wait_all_done();

    // back-to-back stream, then illegal op
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      op = 4'(v_op[i]); rs = 5'(v_rs[i]); rt = 5'(v_rt[i]); rd = 5'(v_rd[i]); imm = 16'(v_im[i]);
      in_valid = 1'b1;
      tick();
      chk($sformatf("b2b%0d.we", i), 32'(we0), 32'd1);
      chk($sformatf("b2b%0d.addr", i), 32'(addr0), 32'(i));
      chk($sformatf("b2b%0d.wdata", i), wd0, v_ex[i]);
    end
    in_valid = 1'b0;
    chk("full4.in_ready", 32'(rdy1), 32'd0);
    chk("full4.count", 32'(cnt1), 32'd4);
    send(12, 3, 3, 3, 3, 1'b0);
    chk("ill.we", 32'(we0), 32'd0);
    chk("ill.count", 32'(cnt0), 32'd5);
    chk("ill.err", 32'(err0), 32'd1);
    chk("full4.busy", 32'(busy1), 32'd1);
    finish = 1'b1; tick(); finish = 1'b0;
    wait_all_done();
    chk("ill.err_done", 32'(err0), 32'd1);
    chk("ill.count_done", 32'(cnt0), 32'd5);
    chk("full4.count_done", 32'(cnt1), 32'd4);
    start = 1'b1; tick(); start = 1'b0;
    chk("restart.err", 32'(err0), 32'd0);
    chk("restart.count", 32'(cnt0), 32'd0);

    // transfer coinciding with finish
    send(0, 1, 2, 3, 0, 1'b0);
    send(1, 4, 5, 6, 0, 1'b0);
    send(3, 7, 8, 9, 0, 1'b1);
    chk("fin.we", 32'(we0), 32'd1);
    chk("fin.addr", 32'(addr0), 32'd2);
    chk("fin.wdata", wd0, 32'h00E84825);
    chk("fin.done", 32'(done0), 32'd0);
    if (PAD_EN) begin
      for (int i = 0; i < 5; i++) begin
        tick();
        chk($sformatf("pad%0d.we", i), 32'(we2), 32'd1);
        chk($sformatf("pad%0d.addr", i), 32'(addr2), 32'(3 + i));
        chk($sformatf("pad%0d.wdata", i), wd2, 32'd0);
        chk($sformatf("pad%0d.count", i), 32'(cnt2), 32'd3);
      end
      tick();
      chk("pad.done", 32'(done2), 32'd1);
    end else begin
      tick();
      chk("fin.done1", 32'(done0), 32'd1);
      chk("fin.we_done", 32'(we0), 32'd0);
      chk("fin.count8", 32'(cnt2), 32'd3);
    end
    wait_all_done();

    // reset on the edge that would launch a write
    start = 1'b1; tick(); start = 1'b0;
    send(12, 0, 0, 0, 0, 1'b0);
    send(0, 1, 2, 3, 0, 1'b0);
    op = 4'd7; rs = 5'd1; rt = 5'd1; imm = 16'd1; in_valid = 1'b1; rst = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("rst2.we", 32'(we0), 32'd0);
    chk("rst2.count", 32'(cnt0), 32'd0);
    chk("rst2.err", 32'(err0), 32'd0);
    chk("rst2.busy", 32'(busy0), 32'd0);
    tick();
    chk("rst2.we_hold", 32'(we0), 32'd0);
    rst = 1'b0;
    tick();
    chk("rst2.idle_ready", 32'(rdy0), 32'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
